fp_normalizer: RTL and testbench
================================

FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL provide parameter EXP_W, default 4, exponent width.
REQ-002 SHALL provide parameter FRAC_W, default 8, significand width; the leading 1 is explicit, so normalized means frac[FRAC_W-1]=1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  raw adder result present.
REQ-007 in_ready  output  1  block can accept an input.
REQ-008 in_sign  input  1  sign of the raw sum.
REQ-009 in_exp  input  EXP_W  exponent of the raw sum, equal to the larger operand exponent.
REQ-010 in_raw  input  FRAC_W+1  raw significand sum; bit FRAC_W is the carry-out.
REQ-011 out_valid  output  1  normalized result held.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sign_out  output  1  result sign.
REQ-014 exp_out  output  EXP_W  result exponent.
REQ-015 frac_out  output  FRAC_W  result significand.
REQ-016 ovf  output  1  exponent overflow, saturated result.
REQ-017 unf  output  1  exponent underflow, denormal result.
REQ-018 zero  output  1  result is exactly zero.

Function
REQ-019 SHALL implement FSM states IDLE, NORM and DONE, with all outputs registered.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 In IDLE, on an edge with in_valid=1, the block SHALL capture sign, exp and raw into working registers and go to NORM (acceptance edge E0).
REQ-022 In NORM, each edge SHALL evaluate exactly one rule, in priority order, from REQ-023 to REQ-027.
REQ-023 raw==0: result sign=0, exp=0, frac=0, zero=1; go to DONE.
REQ-024 raw[FRAC_W]=1 and exp=max (all ones): result exp=max, frac=all ones, ovf=1, sign kept; go to DONE.
REQ-025 raw[FRAC_W]=1 and exp<max: raw SHALL be shifted right 1 (LSB truncated) and exp incremented by 1; stay in NORM.
REQ-026 raw[FRAC_W-1]=1: result = sign, exp, raw[FRAC_W-1:0]; go to DONE.
REQ-027 Otherwise, with exp=0: result exp=0, frac=raw[FRAC_W-1:0], unf=1; go to DONE.
REQ-028 Otherwise, with exp>0: raw SHALL be shifted left 1 and exp decremented by 1; stay in NORM.
REQ-029 Latency: out_valid SHALL rise after edge E0+k+1, where k is the number of shift steps taken (0..FRAC_W-1 left, or at most 1 right).
REQ-030 In DONE, all outputs SHALL hold stable while out_ready=0.
REQ-031 On an edge in DONE with out_ready=1, the block SHALL go to IDLE; out_valid and the flags SHALL clear on that edge.
REQ-032 No new input SHALL be accepted in the cycle of the output handshake; the next acceptance is the earliest edge in IDLE.
REQ-033 ovf, unf and zero SHALL be mutually exclusive, and at most one SHALL be set per result.
REQ-034 Exponent arithmetic SHALL never wrap; saturation or underflow per REQ-024 and REQ-027 applies instead.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, sign_out=0, exp_out=0, frac_out=0, ovf=0, unf=0, zero=0, and clear the working registers.
REQ-036 Reset in any state, including mid-NORM or DONE, SHALL abort the operation with no partial result emitted.
REQ-037 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-038 Carry case: sign=0, exp=9, raw=0x157 -> sign_out=0, exp_out=10, frac_out=0xAB, no flags; out_valid rises after E0+2.
REQ-039 Left shift case: sign=1, exp=4, raw=0x033 -> sign_out=1, exp_out=2, frac_out=0xCC; out_valid rises after E0+3.
REQ-040 Zero case: sign=1, exp=3, raw=0x000 -> sign_out=0, exp_out=0, frac_out=0x00, zero=1; out_valid rises after E0+1.
REQ-041 Overflow case: exp=15, raw=0x180 -> exp_out=15, frac_out=0xFF, ovf=1; out_valid rises after E0+1.
REQ-042 Underflow case: exp=1, raw=0x010 -> exp_out=0, frac_out=0x20, unf=1; out_valid rises after E0+2.
REQ-043 Backpressure and reset case: hold out_ready=0 for 5 cycles and check outputs are stable with in_ready=0; then assert rst mid-NORM on a new input and check every output returns to its reset value one edge later, with no out_valid.

Source files
------------

// File: rtl/fp_normalizer.sv
// fp_normalizer
//   Normalizes the raw significand sum produced by a floating-point adder.
//   One rule is applied per clock in NORM: a carry-out costs one right
//   shift, each missing leading one costs one left shift. The exponent
//   saturates at all-ones (ovf) and stops at zero (unf) instead of wrapping.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready high only in IDLE)
//   in_sign, in_exp, in_raw  raw sum; in_raw[FRAC_W] is the carry-out
//   out_valid / out_ready    output handshake (out_valid high only in DONE)
//   sign_out, exp_out,       normalized result, held stable in DONE
//   frac_out
//   ovf, unf, zero           mutually exclusive result flags
//   dbg_state                current FSM state (0=IDLE, 1=NORM, 2=DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds its data stable while valid=1 and ready=0.
module fp_normalizer #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W:0]   in_raw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              ovf,
    output logic              unf,
    output logic              zero,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [FRAC_W:0]     raw_q, raw_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                sign_out_q, sign_out_d;
    logic [EXP_W-1:0]    exp_out_q, exp_out_d;
    logic [FRAC_W-1:0]   frac_out_q, frac_out_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                zero_q, zero_d;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        raw_d       = raw_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sign_out_d  = sign_out_q;
        exp_out_d   = exp_out_q;
        frac_out_d  = frac_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d     = in_sign;
                    exp_d      = in_exp;
                    raw_d      = in_raw;
                    in_ready_d = 1'b0;
                    state_d    = NORM;
                end
            end

            NORM: begin
                if (raw_q == '0) begin
                    // Exact zero is reported as +0 regardless of input sign.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    sign_out_d  = 1'b0;
                    exp_out_d   = '0;
                    frac_out_d  = '0;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    zero_d      = 1'b1;
                end else if (raw_q[FRAC_W] && (exp_q == EXP_MAX)) begin
                    // No room to absorb the carry: saturate.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    sign_out_d  = sign_q;
                    exp_out_d   = EXP_MAX;
                    frac_out_d  = '1;
                    ovf_d       = 1'b1;
                    unf_d       = 1'b0;
                    zero_d      = 1'b0;
                end else if (raw_q[FRAC_W]) begin
                    raw_d = raw_q >> 1;
                    exp_d = exp_q + EXP_ONE;
                end else if (raw_q[FRAC_W-1]) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    sign_out_d  = sign_q;
                    exp_out_d   = exp_q;
                    frac_out_d  = raw_q[FRAC_W-1:0];
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    zero_d      = 1'b0;
                end else if (exp_q == '0) begin
                    // Exponent exhausted before the leading one arrived.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    sign_out_d  = sign_q;
                    exp_out_d   = '0;
                    frac_out_d  = raw_q[FRAC_W-1:0];
                    ovf_d       = 1'b0;
                    unf_d       = 1'b1;
                    zero_d      = 1'b0;
                end else begin
                    raw_d = raw_q << 1;
                    exp_d = exp_q - EXP_ONE;
                end
            end

            DONE: begin
                // Result data is left in place; only valid and flags drop.
                if (out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    zero_d      = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            raw_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_out_q  <= 1'b0;
            exp_out_q   <= '0;
            frac_out_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            raw_q       <= raw_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sign_out_q  <= sign_out_d;
            exp_out_q   <= exp_out_d;
            frac_out_q  <= frac_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sign_out  = sign_out_q;
    assign exp_out   = exp_out_q;
    assign frac_out  = frac_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_normalizer.sv
module tb_fp_normalizer;

  // Scoreboard entry: {sign, exp[3:0], frac[7:0], ovf, unf, zero, latency[3:0]}
  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [3:0] in_exp;
  logic [8:0] in_raw;
  logic       out_valid;
  logic       out_ready;
  logic       sign_out;
  logic [3:0] exp_out;
  logic [7:0] frac_out;
  logic       ovf;
  logic       unf;
  logic       zero;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  fp_normalizer #(.EXP_W(4), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_raw(in_raw),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
    .ovf(ovf), .unf(unf), .zero(zero), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: leading-one position decides the shift count directly.
  function automatic logic [W-1:0] model(input logic s, input logic [3:0] e, input logic [8:0] r);
    int p;
    int sh;
    int ei;
    logic [7:0] f;
    p  = -1;
    ei = int'(e);
    for (int i = 0; i < 8; i++) if (r[i]) p = i;
    if (r == 9'd0) return {1'b0, 4'd0, 8'd0, 3'b001, 4'd1};
    if (r[8]) begin
      if (e == 4'hF) return {s, 4'hF, 8'hFF, 3'b100, 4'd1};
      return {s, 4'(ei + 1), r[8:1], 3'b000, 4'd2};
    end
    sh = 7 - p;
    if (sh <= ei) begin
      f = r[7:0] << sh;
      return {s, 4'(ei - sh), f, 3'b000, 4'(sh + 1)};
    end
    f = r[7:0] << ei;
    return {s, 4'd0, f, 3'b010, 4'(ei + 1)};
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(in_ready),  32'd0);
    check({tag, ".sign"},      32'(sign_out),  32'(e[19]));
    check({tag, ".exp"},       32'(exp_out),   32'(e[18:15]));
    check({tag, ".frac"},      32'(frac_out),  32'(e[14:7]));
    check({tag, ".flags"},     32'({ovf, unf, zero}), 32'(e[6:4]));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // driver: push expectation, issue one input, collect and retire the result
  task automatic do_op(input string tag, input logic s, input logic [3:0] e,
                       input logic [8:0] r, input int hold);
    logic [W-1:0] expv;
    int edges;
    exp_q.push_back(model(s, e, r));
    wait_ready();
    in_sign  = s;
    in_exp   = e;
    in_raw   = r;
    in_valid = 1'b1;
    @(posedge clk); #1;               // acceptance edge E0
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 30) begin
      @(posedge clk); #1; edges++;
    end
    expv = exp_q.pop_front();
    check({tag, ".latency"}, 32'(edges), 32'(expv[3:0]));
    check_result(tag, expv);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_result({tag, ".hold"}, expv);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(in_ready),  32'd1);
    check({tag, ".post_flags"}, 32'({ovf, unf, zero}), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".sign"},      32'(sign_out),  32'd0);
    check({tag, ".exp"},       32'(exp_out),   32'd0);
    check({tag, ".frac"},      32'(frac_out),  32'd0);
    check({tag, ".flags"},     32'({ovf, unf, zero}), 32'd0);
    check({tag, ".state"},     32'(dbg_state), 32'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b1;                 // reset must win over in_valid
    in_sign   = 1'b1;
    in_exp    = 4'd5;
    in_raw    = 9'h0AA;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_op("carry",     1'b0, 4'd9,  9'h157, 0);
    do_op("left",      1'b1, 4'd4,  9'h033, 5);   // held off for 5 cycles
    do_op("zero",      1'b1, 4'd3,  9'h000, 0);
    do_op("ovf",       1'b0, 4'd15, 9'h180, 0);
    do_op("unf",       1'b0, 4'd1,  9'h010, 0);
    do_op("norm_now",  1'b1, 4'd0,  9'h080, 0);
    do_op("lsb_only",  1'b0, 4'd7,  9'h001, 0);   // seven left shifts, exp reaches 0 exactly
    do_op("exp0_unf",  1'b1, 4'd0,  9'h001, 0);

    // random cases
    for (int i = 0; i < 10; i++)
      do_op("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            9'($urandom_range(0, 511)), int'($urandom_range(0, 2)));

    // reset mid-NORM: leaves last result data in the output registers first
    do_op("pre_abort", 1'b1, 4'd12, 9'h0F0, 0);
    wait_ready();
    in_sign  = 1'b1;
    in_exp   = 4'd10;
    in_raw   = 9'h001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort.in_norm", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("abort");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort.no_valid", 32'(seen), 32'd0);

    do_op("recover", 1'b0, 4'd2, 9'h040, 0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
